plic_claim_ctrl: RTL and testbench

- Hart-side interrupt sequencer: AXI4-Lite initiator that drives one PLIC context through claim, dispatch and complete.
- Watches the context's `target` line, reads claim/complete, presents the ID to the core, waits for service done, then writes the ID back to complete.
- Also serialises software-requested threshold updates onto the same AXI port, so the core never touches the PLIC claim protocol directly.

---
 rtl/plic_claim_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_plic_claim_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/plic_claim_ctrl.sv
// Hart-side PLIC claim/complete sequencer with an AXI4-Lite initiator port.
// Optional: define PLIC_CLAIM_CTRL_SPURIOUS_CNT_EN to add a saturating spurious-claim counter.
module plic_claim_ctrl #(
  parameter int unsigned        AWIDTH      = 32,
  parameter int unsigned        DWIDTH      = 32,
  parameter logic [AWIDTH-1:0]  PLIC_BASE   = 32'h0C00_0000,
  parameter int unsigned        CONTEXT     = 0,
  parameter int unsigned        NUM_SOURCES = 32,
  parameter int unsigned        PRIOW       = 2,
  localparam int unsigned       IDW         = $clog2(NUM_SOURCES),
  localparam int unsigned       STRBW       = DWIDTH / 8
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              target_i,

  input  logic              thr_req_i,
  input  logic [PRIOW-1:0]  thr_data_i,
  output logic              thr_ack_o,

  output logic              irq_valid_o,
  output logic [IDW-1:0]    irq_id_o,
  input  logic              irq_ready_i,
  input  logic              irq_done_i,

  output logic              busy_o,

  output logic [AWIDTH-1:0] araddr_o,
  output logic              arvalid_o,
  input  logic              arready_i,
  input  logic [DWIDTH-1:0] rdata_i,
  input  logic              rvalid_i,
  output logic              rready_o,
  input  logic [1:0]        rresp_i,

  output logic [AWIDTH-1:0] awaddr_o,
  output logic              awvalid_o,
  input  logic              awready_i,
  output logic [DWIDTH-1:0] wdata_o,
  output logic [STRBW-1:0]  wstrb_o,
  output logic              wvalid_o,
  input  logic              wready_i,
  input  logic              bvalid_i,
  output logic              bready_o,
  input  logic [1:0]        bresp_i
`ifdef PLIC_CLAIM_CTRL_SPURIOUS_CNT_EN
  ,
  output logic [15:0]       spurious_cnt_o
`endif
);

  localparam logic [AWIDTH-1:0] THR_ADDR =
    PLIC_BASE + AWIDTH'(32'h0020_0000) + AWIDTH'(CONTEXT * 32'h0000_1000);
  localparam logic [AWIDTH-1:0] CLM_ADDR = THR_ADDR + AWIDTH'(4);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLAIM_AR,
    S_CLAIM_R,
    S_DISPATCH,
    S_SERVICE,
    S_WR_AW_W,
    S_WR_B,
    S_HOLDOFF
  } state_e;

  typedef enum logic {
    K_THR,
    K_CMP
  } kind_e;

  state_e              state_q, state_d;
  kind_e               kind_q;
  logic                aw_ok_q, w_ok_q;
  logic                busy_q;
  logic                thr_ack_q;
  logic                irq_valid_q;
  logic [IDW-1:0]      irq_id_q;
  logic [AWIDTH-1:0]   araddr_q;
  logic                arvalid_q;
  logic                rready_q;
  logic [AWIDTH-1:0]   awaddr_q;
  logic                awvalid_q;
  logic [DWIDTH-1:0]   wdata_q;
  logic                wvalid_q;
  logic                bready_q;

  logic                aw_hs, w_hs;
  logic                aw_done, w_done;
  logic [IDW-1:0]      rd_id;
  logic                spurious;
  logic                in_wr;

  assign aw_hs   = awvalid_q & awready_i;
  assign w_hs    = wvalid_q & wready_i;
  assign aw_done = aw_ok_q | aw_hs;
  assign w_done  = w_ok_q | w_hs;
  assign in_wr   = (state_q == S_WR_AW_W);

  // A claim is spurious when the PLIC returns no source, an out-of-range source, or an error.
  assign rd_id    = rdata_i[IDW-1:0];
  assign spurious = (rd_id == '0) ||
                    (rdata_i >= DWIDTH'(NUM_SOURCES)) ||
                    (rresp_i != 2'b00);

  // NOTE: combinational blocks assign a default first so no path leaves a signal unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (thr_req_i)     state_d = S_WR_AW_W;
        else if (target_i) state_d = S_CLAIM_AR;
      end
      S_CLAIM_AR: if (arvalid_q && arready_i) state_d = S_CLAIM_R;
      S_CLAIM_R:  if (rvalid_i) state_d = spurious ? S_HOLDOFF : S_DISPATCH;
      S_DISPATCH: if (irq_ready_i) state_d = S_SERVICE;
      S_SERVICE:  if (irq_done_i) state_d = S_WR_AW_W;
      S_WR_AW_W:  if (aw_done && w_done) state_d = S_WR_B;
      S_WR_B:     if (bvalid_i) state_d = S_HOLDOFF;
      S_HOLDOFF:  state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      kind_q      <= K_THR;
      aw_ok_q     <= 1'b0;
      w_ok_q      <= 1'b0;
      busy_q      <= 1'b0;
      thr_ack_q   <= 1'b0;
      irq_valid_q <= 1'b0;
      irq_id_q    <= '0;
      araddr_q    <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awaddr_q    <= '0;
      awvalid_q   <= 1'b0;
      wdata_q     <= '0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= (state_d != S_IDLE);
      arvalid_q   <= (state_d == S_CLAIM_AR);
      rready_q    <= (state_d == S_CLAIM_R);
      irq_valid_q <= (state_d == S_DISPATCH);
      bready_q    <= (state_d == S_WR_B);
      thr_ack_q   <= (state_q == S_WR_B) && bvalid_i && (kind_q == K_THR);

      // AW and W retire independently; entering the write state re-arms both.
      awvalid_q   <= (state_d == S_WR_AW_W) && !(in_wr && aw_done);
      wvalid_q    <= (state_d == S_WR_AW_W) && !(in_wr && w_done);
      aw_ok_q     <= (state_d == S_WR_AW_W) && in_wr && aw_done;
      w_ok_q      <= (state_d == S_WR_AW_W) && in_wr && w_done;

      unique case (state_q)
        S_IDLE: begin
          if (thr_req_i) begin
            kind_q   <= K_THR;
            awaddr_q <= THR_ADDR;
            wdata_q  <= DWIDTH'(thr_data_i);
          end else if (target_i) begin
            araddr_q <= CLM_ADDR;
          end
        end
        S_CLAIM_R: begin
          if (rvalid_i && !spurious) irq_id_q <= rd_id;
        end
        S_SERVICE: begin
          if (irq_done_i) begin
            kind_q   <= K_CMP;
            awaddr_q <= CLM_ADDR;
            wdata_q  <= DWIDTH'(irq_id_q);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PLIC_CLAIM_CTRL_SPURIOUS_CNT_EN
  logic [15:0] spurious_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      spurious_cnt_q <= '0;
    end else if ((state_q == S_CLAIM_R) && rvalid_i && spurious &&
                 (spurious_cnt_q != 16'hFFFF)) begin
      spurious_cnt_q <= spurious_cnt_q + 16'd1;
    end
  end

  assign spurious_cnt_o = spurious_cnt_q;
`endif

  // Write responses carry no information this sequencer acts on.
  logic unused_bresp;
  assign unused_bresp = ^bresp_i;

  assign busy_o      = busy_q;
  assign thr_ack_o   = thr_ack_q;
  assign irq_valid_o = irq_valid_q;
  assign irq_id_o    = irq_id_q;
  assign araddr_o    = araddr_q;
  assign arvalid_o   = arvalid_q;
  assign rready_o    = rready_q;
  assign awaddr_o    = awaddr_q;
  assign awvalid_o   = awvalid_q;
  assign wdata_o     = wdata_q;
  assign wstrb_o     = '1;
  assign wvalid_o    = wvalid_q;
  assign bready_o    = bready_q;

endmodule

// File: tb/tb_plic_claim_ctrl.sv
// Self-checking bench for plic_claim_ctrl: directed test-plan steps followed by randomized transactions.
module tb_plic_claim_ctrl;

  localparam int NSRC = 32;

  logic        clk;
  logic        rst;
  logic        target, thr_req, irq_ready, irq_done;
  logic [1:0]  thr_data;
  logic        thr_ack, irq_valid, busy;
  logic [4:0]  irq_id;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  rresp, bresp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;
`ifdef PLIC_CLAIM_CTRL_SPURIOUS_CNT_EN
  logic [15:0] spurious_cnt, spurious_cnt1;
`endif

  // Second instance serving context 1; only its claim address is exercised.
  logic        target1;
  logic        thr_ack1, irq_valid1, busy1, arvalid1, rready1, awvalid1, wvalid1, bready1;
  logic [4:0]  irq_id1;
  logic [31:0] araddr1, awaddr1, wdata1;
  logic [3:0]  wstrb1;

  int checks = 0;
  int errors = 0;
  int spur_model = 0;

  plic_claim_ctrl dut (
    .clk_i(clk), .rst_i(rst), .target_i(target),
    .thr_req_i(thr_req), .thr_data_i(thr_data), .thr_ack_o(thr_ack),
    .irq_valid_o(irq_valid), .irq_id_o(irq_id), .irq_ready_i(irq_ready), .irq_done_i(irq_done),
    .busy_o(busy),
    .araddr_o(araddr), .arvalid_o(arvalid), .arready_i(arready),
    .rdata_i(rdata), .rvalid_i(rvalid), .rready_o(rready), .rresp_i(rresp),
    .awaddr_o(awaddr), .awvalid_o(awvalid), .awready_i(awready),
    .wdata_o(wdata), .wstrb_o(wstrb), .wvalid_o(wvalid), .wready_i(wready),
    .bvalid_i(bvalid), .bready_o(bready), .bresp_i(bresp)
`ifdef PLIC_CLAIM_CTRL_SPURIOUS_CNT_EN
    , .spurious_cnt_o(spurious_cnt)
`endif
  );

  plic_claim_ctrl #(.CONTEXT(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .target_i(target1),
    .thr_req_i(1'b0), .thr_data_i(2'b00), .thr_ack_o(thr_ack1),
    .irq_valid_o(irq_valid1), .irq_id_o(irq_id1), .irq_ready_i(1'b0), .irq_done_i(1'b0),
    .busy_o(busy1),
    .araddr_o(araddr1), .arvalid_o(arvalid1), .arready_i(1'b0),
    .rdata_i(32'h0), .rvalid_i(1'b0), .rready_o(rready1), .rresp_i(2'b00),
    .awaddr_o(awaddr1), .awvalid_o(awvalid1), .awready_i(1'b0),
    .wdata_o(wdata1), .wstrb_o(wstrb1), .wvalid_o(wvalid1), .wready_i(1'b0),
    .bvalid_i(1'b0), .bready_o(bready1), .bresp_i(2'b00)
`ifdef PLIC_CLAIM_CTRL_SPURIOUS_CNT_EN
    , .spurious_cnt_o(spurious_cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] thr_addr(input int ctx);
    return 32'h0C00_0000 + 32'h0020_0000 + ctx * 32'h1000;
  endfunction

  function automatic logic [31:0] clm_addr(input int ctx);
    return thr_addr(ctx) + 32'd4;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_spur_cnt();
`ifdef PLIC_CLAIM_CTRL_SPURIOUS_CNT_EN
    check("spurious_cnt", spurious_cnt, spur_model);
`endif
  endtask

  // Called one cycle after the write was decided; ends in IDLE after HOLDOFF.
  task automatic axi_write(input logic [31:0] ea, input logic [31:0] ed, input bit thr,
                           input int aw_dly, input int w_dly, input int b_dly);
    int mx;
    mx = (aw_dly > w_dly) ? aw_dly : w_dly;
    check("aw_addr", awaddr, ea);
    check("w_data", wdata, ed);
    check("w_strb", wstrb, 4'hF);
    check("awvalid_rise", awvalid, 1'b1);
    check("wvalid_rise", wvalid, 1'b1);
    for (int k = 0; k <= mx; k++) begin
      awready = (k >= aw_dly);
      wready  = (k >= w_dly);
      tick();
      check("awvalid_skew", awvalid, k < aw_dly);
      check("wvalid_skew", wvalid, k < w_dly);
      check("bready_join", bready, k >= mx);
    end
    awready = 1'b0;
    wready  = 1'b0;
    for (int k = 0; k < b_dly; k++) begin
      tick();
      check("bready_wait", bready, 1'b1);
      check("thr_ack_early", thr_ack, 1'b0);
    end
    bvalid = 1'b1;
    bresp  = 2'($urandom_range(0, 3));
    tick();
    bvalid = 1'b0;
    check("thr_ack_pulse", thr_ack, thr);
    check("bready_drop", bready, 1'b0);
    check("holdoff_busy", busy, 1'b1);
    if (thr) thr_req = 1'b0;
    tick();
    check("thr_ack_single", thr_ack, 1'b0);
    check("holdoff_one_cycle", busy, 1'b0);
  endtask

  task automatic thr_txn(input logic [1:0] d, input bit with_target,
                         input int aw_dly, input int w_dly, input int b_dly);
    thr_req  = 1'b1;
    thr_data = d;
    target   = with_target;
    tick();
    check("thr_priority_no_ar", arvalid, 1'b0);
    check("thr_busy", busy, 1'b1);
    axi_write(thr_addr(0), {30'd0, d}, 1'b1, aw_dly, w_dly, b_dly);
    check("thr_then_idle_ar", arvalid, 1'b0);
  endtask

  task automatic claim_txn(input logic [31:0] rd, input logic [1:0] rr, input int ar_dly,
                           input int irdy_dly, input int aw_dly, input int w_dly, input int b_dly);
    bit spur;
    spur = (rd == 0) || (rd >= NSRC) || (rr != 2'b00);
    target = 1'b1;
    tick();
    target = 1'b0;
    check("ar_rise", arvalid, 1'b1);
    check("ar_addr", araddr, clm_addr(0));
    check("claim_busy", busy, 1'b1);
    check("claim_no_aw", awvalid, 1'b0);
    for (int k = 0; k < ar_dly; k++) begin
      tick();
      check("ar_held", arvalid, 1'b1);
      check("ar_addr_held", araddr, clm_addr(0));
    end
    arready = 1'b1;
    tick();
    arready = 1'b0;
    check("ar_drop", arvalid, 1'b0);
    check("rready_rise", rready, 1'b1);
    rvalid = 1'b1;
    rdata  = rd;
    rresp  = rr;
    tick();
    rvalid = 1'b0;
    rdata  = $urandom;
    rresp  = 2'b00;
    check("rready_drop", rready, 1'b0);
    if (spur) begin
      if (spur_model < 16'hFFFF) spur_model++;
      check("spur_no_irq", irq_valid, 1'b0);
      check("spur_no_aw", awvalid | wvalid, 1'b0);
      check("spur_holdoff", busy, 1'b1);
      check_spur_cnt();
      tick();
      check("spur_idle", busy, 1'b0);
      check("spur_no_irq_late", irq_valid, 1'b0);
      check("spur_no_aw_late", awvalid | wvalid, 1'b0);
    end else begin
      check("irq_valid_rise", irq_valid, 1'b1);
      check("irq_id", irq_id, rd[4:0]);
      for (int k = 0; k < irdy_dly; k++) begin
        irq_done = (k == 0);
        tick();
        irq_done = 1'b0;
        check("irq_valid_held", irq_valid, 1'b1);
        check("irq_id_held", irq_id, rd[4:0]);
        check("dispatch_no_aw", awvalid, 1'b0);
      end
      irq_ready = 1'b1;
      tick();
      irq_ready = 1'b0;
      check("irq_valid_drop", irq_valid, 1'b0);
      tick();
      check("service_wait", awvalid, 1'b0);
      check("service_busy", busy, 1'b1);
      irq_done = 1'b1;
      tick();
      irq_done = 1'b0;
      axi_write(clm_addr(0), rd, 1'b0, aw_dly, w_dly, b_dly);
      check_spur_cnt();
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0]  rr;
    int          sel;

    rst = 1'b1;
    target = 1'b0; target1 = 1'b0; thr_req = 1'b0; thr_data = 2'b00;
    irq_ready = 1'b0; irq_done = 1'b0;
    arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    tick();
    tick();
    check("rst_busy", busy, 1'b0);
    check("rst_valids", {arvalid, rready, awvalid, wvalid, bready, irq_valid, thr_ack}, 7'd0);
    check("rst_irq_id", irq_id, 5'd0);
    check_spur_cnt();
    rst = 1'b0;
    tick();
    check("idle_after_rst", busy, 1'b0);

    // Basic claim, spurious claim, threshold priority.
    claim_txn(32'd5, 2'b00, 0, 0, 0, 0, 0);
    claim_txn(32'd0, 2'b00, 0, 0, 0, 0, 0);
    thr_txn(2'd2, 1'b1, 0, 0, 0);
    claim_txn(32'd7, 2'b00, 1, 0, 0, 0, 1);

    // Channel skew both ways and aligned, with irq_ready backpressure.
    claim_txn(32'd9,  2'b00, 0, 10, 3, 0, 0);
    claim_txn(32'd31, 2'b00, 2, 3,  0, 3, 2);
    claim_txn(32'd1,  2'b00, 0, 1,  2, 2, 0);
    claim_txn(32'd32, 2'b00, 0, 0, 0, 0, 0);
    claim_txn(32'd4,  2'b10, 0, 0, 0, 0, 0);
    thr_txn(2'd3, 1'b0, 3, 0, 1);

    // Reset in the middle of a write.
    thr_req = 1'b1; thr_data = 2'd1;
    tick();
    check("mid_aw_valid", awvalid & wvalid, 1'b1);
    rst = 1'b1;
    thr_req = 1'b0;
    tick();
    spur_model = 0;
    check("rst_mid_aw", awvalid, 1'b0);
    check("rst_mid_w", wvalid, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    check_spur_cnt();
    rst = 1'b0;
    tick();
    check("rst_mid_idle", busy, 1'b0);

    // Context 1 claim address.
    target1 = 1'b1;
    tick();
    target1 = 1'b0;
    check("ctx1_ar_valid", arvalid1, 1'b1);
    check("ctx1_ar_addr", araddr1, clm_addr(1));

    // Randomized transactions.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) < 2) begin
        thr_txn(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      end else begin
        sel = $urandom_range(0, 7);
        case (sel)
          0:       rd = 32'd0;
          1:       rd = $urandom_range(32, 40);
          2:       rd = $urandom | 32'h0000_0100;
          default: rd = $urandom_range(1, 31);
        endcase
        rr = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        claim_txn(rd, rr, $urandom_range(0, 3), $urandom_range(0, 4),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
